// File: rtl/scroll_msg_buffer_if.sv
// Message-buffer bus: write port plus the digit-select / character read path
// shared between the scan FSM (master) and the message buffer (slave).
interface scroll_msg_buffer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        digit_sel;
  logic [DATA_W-1:0] char_out;

  modport master (
    output wr_en, wr_addr, wr_data, digit_sel,
    input  char_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, digit_sel,
    output char_out
  );
endinterface

// File: rtl/scroll_msg_buffer.sv
// Scrolling 16-entry character buffer for a 4-digit multiplexed display:
// timed or debounced-button scroll pointer, registered windowed read.
module scroll_msg_buffer #(
  parameter int MSG_LEN        = 16,
  parameter int SCROLL_TICKS   = 25_000_000,
  parameter int DEBOUNCE_TICKS = 500_000,
  parameter int CNT_W          = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       auto_en,
  input  logic                       btn,
  input  logic                       dir,
  scroll_msg_buffer_if.slave         bus,
  output logic [$clog2(MSG_LEN)-1:0] ptr,
  output logic                       step_pulse
);

  localparam int PTR_W = $clog2(MSG_LEN);
  localparam logic [CNT_W-1:0] SCROLL_LAST   = CNT_W'(SCROLL_TICKS - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    PRESSED,
    WAIT_LOW
  } dbc_state_e;

  // Button synchronizer
  logic sync1_q, btn_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample pre-edge values and form a real 2-stage chain.
      sync1_q <= btn;
      btn_s_q <= sync1_q;
    end
  end

  // Debounce FSM: state register
  dbc_state_e       dbc_state_q, dbc_state_d;
  logic [CNT_W-1:0] dbc_cnt_q, dbc_cnt_d;
  logic             btn_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbc_state_q <= IDLE_LOW;
      dbc_cnt_q   <= '0;
    end else begin
      dbc_state_q <= dbc_state_d;
      dbc_cnt_q   <= dbc_cnt_d;
    end
  end

  // Debounce FSM: next state
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    dbc_state_d = dbc_state_q;
    dbc_cnt_d   = dbc_cnt_q;
    unique case (dbc_state_q)
      IDLE_LOW: if (btn_s_q) begin
        dbc_state_d = WAIT_HIGH;
        dbc_cnt_d   = '0;
      end
      WAIT_HIGH: begin
        if (!btn_s_q)                      dbc_state_d = IDLE_LOW;
        else if (dbc_cnt_q == DEBOUNCE_LAST) dbc_state_d = PRESSED;
        else                               dbc_cnt_d   = dbc_cnt_q + 1'b1;
      end
      PRESSED: if (!btn_s_q) begin
        dbc_state_d = WAIT_LOW;
        dbc_cnt_d   = '0;
      end
      WAIT_LOW: begin
        if (btn_s_q)                       dbc_state_d = PRESSED;
        else if (dbc_cnt_q == DEBOUNCE_LAST) dbc_state_d = IDLE_LOW;
        else                               dbc_cnt_d   = dbc_cnt_q + 1'b1;
      end
      default: dbc_state_d = IDLE_LOW;
    endcase
  end

  // Debounce FSM: output -- fires only on the WAIT_HIGH -> PRESSED transition
  always_comb begin
    btn_pulse = (dbc_state_q == WAIT_HIGH) && btn_s_q && (dbc_cnt_q == DEBOUNCE_LAST);
  end

  // Step source, pointer, read and write datapath
  logic [CNT_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic             step;
  logic [PTR_W-1:0] ptr_q, ptr_d, rd_idx;
  logic             step_pulse_q;
  logic [3:0]       char_out_q, char_out_d;
  logic [3:0]       msg_q [MSG_LEN];
  logic [3:0]       msg_d [MSG_LEN];

  always_comb begin
    scroll_cnt_d = '0;
    step         = 1'b0;
    if (auto_en) begin
      if (scroll_cnt_q == SCROLL_LAST) step = 1'b1;
      else                             scroll_cnt_d = scroll_cnt_q + 1'b1;
    end else begin
      step = btn_pulse;
    end

    ptr_d = ptr_q;
    if (step) ptr_d = dir ? ptr_q - 1'b1 : ptr_q + 1'b1;

    // Read uses the pre-update pointer and pre-write message contents
    rd_idx     = ptr_q + PTR_W'(bus.digit_sel);
    char_out_d = msg_q[rd_idx];

    msg_d = msg_q;
    if (bus.wr_en) msg_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_cnt_q <= '0;
      ptr_q        <= '0;
      step_pulse_q <= 1'b0;
      char_out_q   <= '0;
      // NOTE: the message is flops, not RAM, because reset must restore the identity pattern.
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 4'(i);
    end else begin
      scroll_cnt_q <= scroll_cnt_d;
      ptr_q        <= ptr_d;
      step_pulse_q <= step;
      char_out_q   <= char_out_d;
      msg_q        <= msg_d;
    end
  end

  assign ptr          = ptr_q;
  assign step_pulse   = step_pulse_q;
  assign bus.char_out = char_out_q;

endmodule
